// File: rtl/cu_pkg.sv
// Shared encodings for the control-unit sequencer: PC functions, offset
// selects, CU state codes and status bit positions.
package cu_pkg;

    typedef enum logic [1:0] {
        PCF_HOLD  = 2'b00,
        PCF_PLUS4 = 2'b01,
        PCF_IN    = 2'b10,
        PCF_JUMP  = 2'b11
    } pc_fs_e;

    typedef enum logic [2:0] {
        K_NONE  = 3'b000,
        K_IMM26 = 3'b010,
        K_IMM19 = 3'b011
    } k_mux_e;

    typedef enum logic [3:0] {
        FETCH = 4'b0000,
        EX0   = 4'b0001,
        EX1   = 4'b0010
    } cu_state_e;

    localparam int unsigned V = 3;
    localparam int unsigned C = 2;
    localparam int unsigned N = 1;
    localparam int unsigned Z = 0;

endpackage

// File: rtl/branch_offset_gen.sv
// Combinational branch offset: sign-extends the selected immediate field of
// the instruction and scales it to a byte offset (word << 2).
module branch_offset_gen
    import cu_pkg::*;
#(
    parameter int PC_WIDTH = 64
) (
    input  logic [25:0]         imm,
    input  logic [2:0]          k_mux,
    output logic [PC_WIDTH-1:0] k_offset
);

    logic [PC_WIDTH-1:0] imm26_ext;
    logic [PC_WIDTH-1:0] imm19_ext;

    assign imm26_ext = {{(PC_WIDTH-26){imm[25]}}, imm[25:0]};
    assign imm19_ext = {{(PC_WIDTH-19){imm[23]}}, imm[23:5]};

    always_comb begin
        k_offset = '0;
        case (k_mux)
            K_IMM26: k_offset = imm26_ext << 2;
            K_IMM19: k_offset = imm19_ext << 2;
            default: k_offset = '0;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// Sequencing back end for the control units: PC, IR, VCNZ status and CU state
// registers, driven by the PC_FS / IR_load / status_load / NS control fields.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          NS,
    input  logic [1:0]          PC_FS,
    input  logic [2:0]          k_mux,
    input  logic                IR_load,
    input  logic                status_load,
    input  logic [31:0]         instr_in,
    input  logic [3:0]          alu_flags,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic [3:0]          state,
    output logic [31:0]         IR,
    output logic [3:0]          status,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] k_offset
);

    logic [3:0]          state_reg;
    logic [31:0]         ir_reg;
    logic [3:0]          status_reg;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] pc_next;

    // Offset always comes from the registered IR, so a same-edge IR_load
    // cannot disturb the branch target being taken.
    branch_offset_gen #(
        .PC_WIDTH (PC_WIDTH)
    ) u_offset (
        .imm      (ir_reg[25:0]),
        .k_mux    (k_mux),
        .k_offset (k_offset)
    );

    assign pc_plus4 = pc_reg + PC_WIDTH'(4);

    always_comb begin
        pc_next = pc_reg;
        case (PC_FS)
            PCF_HOLD:  pc_next = pc_reg;
            PCF_PLUS4: pc_next = pc_plus4;
            PCF_IN:    pc_next = pc_in;
            PCF_JUMP:  pc_next = pc_reg + k_offset;
            default:   pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_reg     <= RESET_PC;
            state_reg  <= FETCH;
            ir_reg     <= '0;
            status_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            state_reg <= NS;
            if (IR_load)
                ir_reg <= instr_in;
            if (status_load)
                status_reg <= alu_flags;
        end
    end

    assign state  = state_reg;
    assign IR     = ir_reg;
    assign status = status_reg;
    assign PC     = pc_reg;

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Sequencing back end for the control units: holds the program counter, instruction register, VCNZ status register and control-unit state register, and applies the PC_FS, IR_load, status_load and NS fields that the control units emit. It sits between instruction memory, the ALU flag outputs and the control units. Every CU reads `state`, `status` and `IR` from this block, and every CU drives its next-state and PC control back into it.

## Interface
Parameters:
- PC_WIDTH, 64, width of PC and of the branch/link datapath
- RESET_PC, 0, PC value loaded on reset

Ports:
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all registers immediately
- NS  in  4  next CU state
- PC_FS  in  2  PC function: 00 hold, 01 PC+4, 10 load pc_in, 11 PC+offset
- k_mux  in  3  offset select: 010 imm26, 011 imm19, others zero
- IR_load  in  1  capture instr_in into IR
- status_load  in  1  capture alu_flags into status
- instr_in  in  32  instruction word from instruction memory
- alu_flags  in  4  {V,C,N,Z} from ALU
- pc_in  in  PC_WIDTH  register value for indirect branch (BR)
- state  out  4  registered CU state
- IR  out  32  registered instruction
- status  out  4  registered {V,C,N,Z}
- PC  out  PC_WIDTH  current program counter
- pc_plus4  out  PC_WIDTH  PC+4, combinational; link value for BL
- k_offset  out  PC_WIDTH  sign-extended, word-scaled offset (debug/datapath)

## Operation
- Offset generation, combinational:
  - k_mux=010: sext(IR[25:0])<<2
  - k_mux=011: sext(IR[23:5])<<2
  - any other code: 0
- PC next value:
  - PC_FS 00: PC
  - PC_FS 01: PC+4
  - PC_FS 10: pc_in
  - PC_FS 11: PC+k_offset
- All PC arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- state <= NS every cycle, unconditionally.
- IR <= instr_in when IR_load=1, else holds.
- status <= alu_flags when status_load=1, else holds.
- All four registers update independently in the same edge, using pre-edge values of IR and PC. When IR_load and PC_FS=11 occur together, the offset comes from the old IR.
- PC_FS=10 with an unaligned pc_in loads the value as given; no alignment check.

## Timing
- Reset (reset=0, asynchronous):
  - PC=RESET_PC
  - state=4'b0000
  - IR=32'b0
  - status=4'b0000
- Reset deassertion is synchronized externally; the first update is on the first rising edge with reset=1.
- Latency of every register is one cycle from its control input to its output. pc_plus4 and k_offset have zero-cycle latency from PC/IR/k_mux.
- Control inputs are sampled only at rising edges; glitches between edges are ignored.
- Reset asserted mid-instruction (state≠0) aborts the instruction. No partial writes survive: status and IR return to 0, state returns to fetch (0000).

## Structure
- Shared package `cu_pkg` holds:
  - PC_FS encodings (PCF_HOLD, PCF_PLUS4, PCF_IN, PCF_JUMP)
  - k_mux encodings (K_NONE=000, K_IMM26=010, K_IMM19=011)
  - state encodings (FETCH=0000, EX0=0001, EX1=0010)
  - status bit indices V=3, C=2, N=1, Z=0
- One sub-module, `branch_offset_gen`, handles the combinational IR+k_mux to k_offset generation. PC adder, mux and registers stay in the top.

## Test plan
- Reset: assert reset=0 mid-cycle with PC=0x40 and state=0010 -> PC=0, state=0, IR=0 and status=0 immediately, without waiting for a clock edge.
- Sequential fetch: PC_FS=01 for 3 cycles from PC=0 -> PC=4, 8, 0xC; pc_plus4 is always PC+4.
- B backward: IR=0x17FFFFFE (imm26=-2), k_mux=010, PC_FS=11, PC=0x100 -> next PC=0xF8.
- CBZ forward: IR imm19=+3 at IR[23:5], k_mux=011, PC_FS=11, PC=0x20 -> PC=0x2C.
- BR: pc_in=0x1234, PC_FS=10 -> PC=0x1234. Same edge with IR_load=1, instr_in=0xD61F0000 -> IR updates and the PC target is unaffected.
- Status/state: status_load=1, alu_flags=1001 -> status=1001; then status_load=0, alu_flags=0110 -> status holds 1001. NS sequence 0001, 0010, 0000 appears on state one cycle later each. PC=0xFFFF_FFFF_FFFF_FFFC with PC_FS=01 -> PC wraps to 0.
